// File: rtl/pwb_pkg.sv
// Shared defaults, derived constants, FSM states and byte-parity helper for prefetch_window_buf.
// The PWB_PARITY_EN macro adds per-byte even parity to the banks.
package pwb_pkg;
  localparam int unsigned PWB_DATA_W    = 64;
  localparam int unsigned PWB_DEPTH     = 256;
  localparam int unsigned PWB_WIN_WORDS = 32;
  localparam int unsigned PWB_NBANK     = 4;
  localparam int unsigned PWB_AW        = $clog2(PWB_DEPTH);
  localparam int unsigned PWB_BEATS     = PWB_WIN_WORDS / PWB_NBANK;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LAST  = 2'd2,
    ST_DONE  = 2'd3
  } pwb_state_e;

  // Even parity: the stored bit makes the byte plus parity bit an even count of ones.
  function automatic logic byte_par(input logic [7:0] b);
    return ^b;
  endfunction
endpackage

// File: rtl/pwb_bank.sv
// One interleaved storage bank: 1 write / 1 registered read port, read-first on collision.
// With PWB_PARITY_EN each row also keeps one even-parity bit per data byte.
module pwb_bank import pwb_pkg::*; #(
  parameter int unsigned DATA_W = PWB_DATA_W,
  parameter int unsigned ROWS   = PWB_DEPTH / PWB_NBANK,
  localparam int unsigned RW    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [RW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [RW-1:0]     raddr,
`ifdef PWB_PARITY_EN
  output logic [DATA_W/8-1:0] rpar,
`endif
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [ROWS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

`ifdef PWB_PARITY_EN
  localparam int unsigned PW = DATA_W / 8;
  logic [PW-1:0] par_mem [ROWS];
  logic [PW-1:0] wpar;

  always_comb begin
    wpar = '0;
    for (int b = 0; b < PW; b++) wpar[b] = byte_par(wdata[b*8 +: 8]);
  end

  always_ff @(posedge clk) begin
    if (we) par_mem[waddr] <= wpar;
    rpar <= par_mem[raddr];
  end
`endif
endmodule

// File: rtl/prefetch_window_buf.sv
// Word-addressed staging buffer returning a WIN_WORDS window (wrapping modulo DEPTH)
// gathered from NBANK banks over BEATS beats. Optional parity checking: PWB_PARITY_EN.
module prefetch_window_buf import pwb_pkg::*; #(
  parameter int unsigned DATA_W    = PWB_DATA_W,
  parameter int unsigned DEPTH     = PWB_DEPTH,
  parameter int unsigned WIN_WORDS = PWB_WIN_WORDS,
  parameter int unsigned NBANK     = PWB_NBANK,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        we,
  input  logic [AW-1:0]               wr_addr,
  input  logic [DATA_W-1:0]           data_in,
  input  logic                        read_req,
  input  logic [AW-1:0]               rd_addr,
  output logic                        busy,
  output logic                        data_valid,
  output logic [WIN_WORDS*DATA_W-1:0] data_out,
  output logic                        rd_perr
);
  localparam int unsigned BEATS = WIN_WORDS / NBANK;
  localparam int unsigned BW    = $clog2(NBANK);
  localparam int unsigned RW    = AW - BW;
  localparam int unsigned WW    = $clog2(WIN_WORDS);
  localparam int unsigned CBW   = (BEATS > 1) ? $clog2(BEATS) : 1;

  pwb_state_e        state_q, state_d;
  logic [CBW-1:0]    beat_q, beat_d, cap_beat_q, cap_beat_d;
  logic [AW-1:0]     base_q, base_d;
  logic              busy_d, valid_d, cap_vld_q, cap_vld_d, accept;

  logic [BW-1:0]     lane       [NBANK];
  logic [RW-1:0]     bank_raddr [NBANK];
  logic [DATA_W-1:0] bank_rdata [NBANK];
  logic [WW-1:0]     slot       [NBANK];
  logic [DATA_W-1:0] win_q      [WIN_WORDS];
`ifdef PWB_PARITY_EN
  logic [DATA_W/8-1:0] bank_rpar [NBANK];
`endif

  assign accept = (state_q == ST_IDLE) && read_req;

  // Bank k serves the window word of the current beat that lands in bank k.
  always_comb begin
    for (int k = 0; k < NBANK; k++) begin
      lane[k]       = BW'(k) - base_q[BW-1:0];
      bank_raddr[k] = RW'((base_q + AW'({beat_q, BW'(0)}) + AW'(lane[k])) >> BW);
      slot[k]       = WW'({cap_beat_q, lane[k]});
    end
  end

  for (genvar k = 0; k < NBANK; k++) begin : g_bank
    pwb_bank #(.DATA_W(DATA_W), .ROWS(DEPTH / NBANK)) u_bank (
      .clk   (clk),
      .we    (we && (wr_addr[BW-1:0] == BW'(k))),
      .waddr (wr_addr[AW-1:BW]),
      .wdata (data_in),
      .raddr (bank_raddr[k]),
`ifdef PWB_PARITY_EN
      .rpar  (bank_rpar[k]),
`endif
      .rdata (bank_rdata[k])
    );
  end

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    base_d     = base_q;
    busy_d     = 1'b0;
    valid_d    = 1'b0;
    cap_vld_d  = 1'b0;
    cap_beat_d = cap_beat_q;
    case (state_q)
      ST_IDLE: begin
        if (read_req) begin
          state_d = ST_FETCH;
          beat_d  = '0;
          base_d  = rd_addr;
          busy_d  = 1'b1;
        end
      end
      ST_FETCH: begin
        busy_d     = 1'b1;
        cap_vld_d  = 1'b1;
        cap_beat_d = beat_q;
        if (beat_q == CBW'(BEATS - 1)) state_d = ST_LAST;
        else beat_d = beat_q + CBW'(1);
      end
      ST_LAST: begin
        state_d = ST_DONE;
        valid_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      beat_q     <= '0;
      base_q     <= '0;
      busy       <= 1'b0;
      data_valid <= 1'b0;
      cap_vld_q  <= 1'b0;
      cap_beat_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      base_q     <= base_d;
      busy       <= busy_d;
      data_valid <= valid_d;
      cap_vld_q  <= cap_vld_d;
      cap_beat_q <= cap_beat_d;
    end
  end

  // Registered bank outputs land in their window slots one cycle after the beat read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WIN_WORDS; i++) win_q[i] <= '0;
    end else if (cap_vld_q) begin
      for (int k = 0; k < NBANK; k++) win_q[slot[k]] <= bank_rdata[k];
    end
  end

  for (genvar i = 0; i < WIN_WORDS; i++) begin : g_out
    assign data_out[i*DATA_W +: DATA_W] = win_q[i];
  end

`ifdef PWB_PARITY_EN
  logic perr_now, err_q, perr_q;

  always_comb begin
    perr_now = 1'b0;
    for (int k = 0; k < NBANK; k++)
      for (int b = 0; b < DATA_W / 8; b++)
        if (byte_par(bank_rdata[k][b*8 +: 8]) != bank_rpar[k][b]) perr_now = 1'b1;
    perr_now = perr_now & cap_vld_q;
  end

  // Sticky across the read, reported alongside data_valid, cleared by the next accepted request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      if (accept) err_q <= 1'b0;
      else if (perr_now) err_q <= 1'b1;
      perr_q <= valid_d & (err_q | perr_now);
    end
  end

  assign rd_perr = perr_q;
`else
  assign rd_perr = 1'b0;
`endif
endmodule
